amb_mem: RTL and testbench
==========================

AMB_MEM -- requirements
Module: amb_mem

Interface
REQ-001 SHALL take widths OPCODE_W, ADDR_W and DATA_W from the shared def.h; LD_W = max(OPCODE_W+ADDR_W, DATA_W), also defined in def.h.
REQ-002 Port clk, input, 1 bit: the only clock; all state is updated on its rising edge.
REQ-003 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 Port pc, input, ADDR_W bits: instruction fetch address from the CPU.
REQ-005 Port opcode, output, OPCODE_W bits: fetched opcode field.
REQ-006 Port operand, output, ADDR_W bits: fetched operand field; also used as the data address.
REQ-007 Port ddatain, output, DATA_W bits: data memory read data at address operand.
REQ-008 Port we, input, 1 bit: CPU store enable.
REQ-009 Port wdata, input, DATA_W bits: CPU store data (the CPU accumulator).
REQ-010 Port cpu_rst_n, output, 1 bit: active-low reset driven to the CPU.
REQ-011 Port ld_valid, input, 1 bit: loader word valid.
REQ-012 Port ld_ready, output, 1 bit: loader word accepted.
REQ-013 Port ld_sel, input, 1 bit: loader target, 0 = instruction memory, 1 = data memory.
REQ-014 Port ld_addr, input, ADDR_W bits: loader word address.
REQ-015 Port ld_data, input, LD_W bits: loader word data.
REQ-016 Port ld_done, input, 1 bit: loader end-of-image pulse.
REQ-017 Port ld_start, input, 1 bit: request to re-enter load mode.
REQ-018 Port running, output, 1 bit: high while the FSM is in RUN.
REQ-019 Port run_cnt, output, 16 bits: cycles spent in RUN, saturating.

Function
REQ-020 SHALL hold an instruction memory and a data memory, each 2**ADDR_W words; instruction words are OPCODE_W+ADDR_W bits and data words are DATA_W bits.
REQ-021 Instruction read SHALL be combinational: {opcode, operand} = imem[pc], with opcode taken from the upper OPCODE_W bits.
REQ-022 Data read SHALL be combinational: ddatain = dmem[operand], so the single-cycle CPU sees data in the same cycle.
REQ-023 The FSM SHALL have exactly three states: LOAD, RELEASE and RUN.
REQ-024 In LOAD: ld_ready = 1 and cpu_rst_n = 0; a word is written when ld_valid & ld_ready, to imem[ld_addr] (ld_data[OPCODE_W+ADDR_W-1:0]) if ld_sel = 0, or to dmem[ld_addr] (ld_data[DATA_W-1:0]) if ld_sel = 1.
REQ-025 LOAD -> RELEASE on ld_done; a word valid in the same cycle as ld_done SHALL still be written.
REQ-026 In RELEASE: cpu_rst_n = 0 and ld_ready = 0; the FSM SHALL move unconditionally to RUN on the next cycle.
REQ-027 In RUN: cpu_rst_n = 1, ld_ready = 0, and ld_valid SHALL be ignored.
REQ-028 In RUN, we = 1 SHALL write wdata to dmem[operand] at the clock edge; the read in that cycle returns the old value.
REQ-029 In any state other than RUN, we SHALL be ignored.
REQ-030 RUN -> LOAD on ld_start; cpu_rst_n SHALL be 0 from the cycle after ld_start; a CPU write in the ld_start cycle SHALL still complete.
REQ-031 ld_start in LOAD or RELEASE SHALL have no effect; ld_done outside LOAD SHALL have no effect.
REQ-032 run_cnt SHALL clear on entry to RELEASE, increment once per RUN cycle, saturate at 16'hFFFF, and hold its value in LOAD.
REQ-033 Memory contents SHALL persist across LOAD/RUN transitions; only loader writes and CPU writes change them.

Reset
REQ-034 On rst_n = 0, asynchronously: state = LOAD, cpu_rst_n = 0, run_cnt = 0, running = 0.
REQ-035 Reset SHALL NOT clear memory contents.
REQ-036 Reset asserted during RUN SHALL force cpu_rst_n = 0 in the same cycle; ld_ready = 1 once rst_n deasserts.

Structure
REQ-037 LD_W and the state encodings (LOAD, RELEASE, RUN) SHALL live in def.h next to the existing widths and opcodes.
REQ-038 SHALL use one sub-module, amb_ram: parameterized width and depth, async read, sync write; instantiated twice (imem, dmem).
REQ-039 The FSM, loader mux and run_cnt SHALL live in amb_mem.

Verification (bench: OPCODE_W = 4, ADDR_W = 8, DATA_W = 16)
REQ-040 Load imem[0] = 12'h305 and dmem[5] = 16'h00AA, then pulse ld_done -> cpu_rst_n stays 0 through RELEASE and rises 2 cycles after ld_done; with pc = 0, opcode = 4'h3, operand = 8'h05, ddatain = 16'h00AA.
REQ-041 In RUN, drive we = 1, wdata = 16'h1234 with operand = 5 -> ddatain = 16'h00AA in that cycle and 16'h1234 in the next.
REQ-042 Drive ld_valid = 1, ld_sel = 1, ld_addr = 5, ld_data = 16'hFFFF during RUN -> ld_ready = 0 and dmem[5] is unchanged.
REQ-043 Pulse ld_start in RUN together with we = 1 -> the write lands, cpu_rst_n = 0 and ld_ready = 1 the next cycle, run_cnt is frozen.
REQ-044 Stay in RUN 70000 cycles -> run_cnt = 16'hFFFF and stays there.
REQ-045 Assert rst_n low mid-RUN -> cpu_rst_n = 0 and run_cnt = 0 immediately, state = LOAD, and dmem[5] keeps its value.

Source files
------------

// File: rtl/amb_mem_pkg.sv
// Shared definitions for the amb_mem instruction/data memory block.
// Holds the datapath widths, the loader word width and the FSM state encoding.
// These are used by the interface, the RAM wrapper users and the top level.
package amb_mem_pkg;

  localparam int OPCODE_W = 4;
  localparam int ADDR_W   = 8;
  localparam int DATA_W   = 16;

  // An instruction word is the opcode field above the operand field.
  localparam int INSTR_W  = OPCODE_W + ADDR_W;

  // A loader word must carry either kind of memory word.
  localparam int LD_W     = (INSTR_W > DATA_W) ? INSTR_W : DATA_W;

  localparam int CNT_W    = 16;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } state_e;

endpackage

// File: rtl/amb_mem_if.sv
// Loader bus for amb_mem.
// Signals:
//   ld_valid  - loader word valid (loader -> memory)
//   ld_ready  - loader word accepted (memory -> loader)
//   ld_sel    - target memory: 0 = instruction, 1 = data
//   ld_addr   - word address
//   ld_data   - word data, LD_W bits
//   ld_done   - end-of-image pulse
//   ld_start  - request to re-enter load mode
// Modports: master = loader side, slave = amb_mem side.
interface amb_mem_if;
  import amb_mem_pkg::*;

  logic              ld_valid;
  logic              ld_ready;
  logic              ld_sel;
  logic [ADDR_W-1:0] ld_addr;
  logic [LD_W-1:0]   ld_data;
  logic              ld_done;
  logic              ld_start;

  modport master (
    output ld_valid, ld_sel, ld_addr, ld_data, ld_done, ld_start,
    input  ld_ready
  );

  modport slave (
    input  ld_valid, ld_sel, ld_addr, ld_data, ld_done, ld_start,
    output ld_ready
  );

endinterface

// File: rtl/amb_ram.sv
// Simple single-port-write RAM with an asynchronous read port.
// Contents are never reset.
// Ports:
//   clk   - write clock
//   we    - write enable
//   waddr - write address
//   wdata - write data
//   raddr - read address (combinational read)
//   rdata - read data
module amb_ram #(
  parameter int WIDTH = 16,
  parameter int AW    = 8
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // A read in the same cycle as a write to that address returns the old word.
  assign rdata = mem[raddr];

endmodule

// File: rtl/amb_mem.sv
// amb_mem: instruction and data memory for a single-cycle CPU, with a loader
// front end and a LOAD -> RELEASE -> RUN control FSM.
// Ports:
//   clk       - clock, all state updates on the rising edge
//   rst_n     - asynchronous active-low reset
//   pc        - instruction fetch address
//   opcode    - fetched opcode field
//   operand   - fetched operand field, also the data address
//   ddatain   - data memory read data at operand
//   we        - CPU store enable (honoured only in RUN)
//   wdata     - CPU store data
//   cpu_rst_n - active-low reset to the CPU (high only in RUN)
//   ld        - loader bus (slave side)
//   running   - high while in RUN
//   run_cnt   - RUN cycle count, saturating
module amb_mem
  import amb_mem_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   pc,
  output logic [OPCODE_W-1:0] opcode,
  output logic [ADDR_W-1:0]   operand,
  output logic [DATA_W-1:0]   ddatain,
  input  logic                we,
  input  logic [DATA_W-1:0]   wdata,
  output logic                cpu_rst_n,
  amb_mem_if.slave            ld,
  output logic                running,
  output logic [CNT_W-1:0]    run_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  state_e state;
  state_e state_nxt;

  logic               in_load;
  logic               in_run;
  logic               load_wr;
  logic               cpu_wr;
  logic               imem_we;
  logic               dmem_we;
  logic [ADDR_W-1:0]  dmem_waddr;
  logic [DATA_W-1:0]  dmem_wdata;
  logic [INSTR_W-1:0] instr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_load   = 1'b0;
    in_run    = 1'b0;
    case (state)
      LOAD: begin
        in_load = 1'b1;
        if (ld.ld_done) state_nxt = RELEASE;
      end
      RELEASE: begin
        state_nxt = RUN;
      end
      RUN: begin
        in_run = 1'b1;
        if (ld.ld_start) state_nxt = LOAD;
      end
      default: begin
        state_nxt = LOAD;
      end
    endcase
  end

  // Outputs decode straight from state, so an async reset drops cpu_rst_n
  // in the same cycle it is asserted.
  assign ld.ld_ready = in_load;
  assign running     = in_run;
  assign cpu_rst_n   = in_run;

  // Loader and CPU never write in the same state, so the dmem port mux
  // only needs to pick by who is active.
  assign load_wr    = in_load & ld.ld_valid;
  assign cpu_wr     = in_run & we;
  assign imem_we    = load_wr & ~ld.ld_sel;
  assign dmem_we    = (load_wr & ld.ld_sel) | cpu_wr;
  assign dmem_waddr = cpu_wr ? operand : ld.ld_addr;
  assign dmem_wdata = cpu_wr ? wdata : ld.ld_data[DATA_W-1:0];

  amb_ram #(
    .WIDTH (INSTR_W),
    .AW    (ADDR_W)
  ) u_imem (
    .clk   (clk),
    .we    (imem_we),
    .waddr (ld.ld_addr),
    .wdata (ld.ld_data[INSTR_W-1:0]),
    .raddr (pc),
    .rdata (instr)
  );

  amb_ram #(
    .WIDTH (DATA_W),
    .AW    (ADDR_W)
  ) u_dmem (
    .clk   (clk),
    .we    (dmem_we),
    .waddr (dmem_waddr),
    .wdata (dmem_wdata),
    .raddr (operand),
    .rdata (ddatain)
  );

  assign opcode  = instr[INSTR_W-1 -: OPCODE_W];
  assign operand = instr[ADDR_W-1:0];

  // Cleared on the LOAD->RELEASE edge, counts RUN cycles, held elsewhere.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt <= '0;
    end else if (in_load && (state_nxt == RELEASE)) begin
      run_cnt <= '0;
    end else if (in_run) begin
      run_cnt <= sat_inc(run_cnt);
    end
  end

endmodule

// File: tb/tb_amb_mem.sv
// Testbench for amb_mem: table-driven loader and fetch vectors with a
// scoreboard of expected output values, plus hand-written sequences for
// store timing, loader lockout, ld_start, counter saturation and reset.
module tb_amb_mem;
  import amb_mem_pkg::*;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [ADDR_W-1:0]   pc;
  logic [OPCODE_W-1:0] opcode;
  logic [ADDR_W-1:0]   operand;
  logic [DATA_W-1:0]   ddatain;
  logic                we;
  logic [DATA_W-1:0]   wdata;
  logic                cpu_rst_n;
  logic                running;
  logic [CNT_W-1:0]    run_cnt;

  amb_mem_if ld();

  amb_mem dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pc        (pc),
    .opcode    (opcode),
    .operand   (operand),
    .ddatain   (ddatain),
    .we        (we),
    .wdata     (wdata),
    .cpu_rst_n (cpu_rst_n),
    .ld        (ld),
    .running   (running),
    .run_cnt   (run_cnt)
  );

  always #5 clk = ~clk;

  typedef enum {S_OPCODE, S_OPERAND, S_DDATA, S_CPURST, S_READY, S_RUNNING, S_RUNCNT} sig_e;
  typedef struct {
    sig_e        sig;
    logic [31:0] val;
    string       name;
  } exp_t;

  typedef struct {
    logic        sel;
    logic [7:0]  addr;
    logic [15:0] data;
  } ldv_t;

  typedef struct {
    logic [7:0]  pc;
    logic [3:0]  op;
    logic [7:0]  opnd;
    logic [15:0] dd;
  } rdv_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   exp_cnt = 0;
  bit   model_run = 1'b0;

  function automatic logic [31:0] probe(input sig_e s);
    case (s)
      S_OPCODE:  return 32'(opcode);
      S_OPERAND: return 32'(operand);
      S_DDATA:   return 32'(ddatain);
      S_CPURST:  return 32'(cpu_rst_n);
      S_READY:   return 32'(ld.ld_ready);
      S_RUNNING: return 32'(running);
      default:   return 32'(run_cnt);
    endcase
  endfunction

  task automatic want(input sig_e s, input logic [31:0] v, input string nm);
    exp_t e;
    e.sig  = s;
    e.val  = v;
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] a;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      a = probe(e.sig);
      n_vec++;
      if (a !== e.val) begin
        n_err++;
        $display("FAIL %s: got %0h, expected %0h", e.name, a, e.val);
      end
    end
  endtask

  // One clock: the expected run counter advances for every edge taken in RUN.
  task automatic tick();
    @(posedge clk);
    if (model_run && exp_cnt < 65535) exp_cnt++;
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog expired");
  end

  ldv_t lt[8];
  rdv_t rt[4];

  initial begin
    lt[0] = '{1'b0, 8'd0,   16'hC305};
    lt[1] = '{1'b1, 8'd5,   16'h00AA};
    lt[2] = '{1'b0, 8'd1,   16'h5A07};
    lt[3] = '{1'b1, 8'd7,   16'hBEEF};
    lt[4] = '{1'b0, 8'd2,   16'h0F00};
    lt[5] = '{1'b1, 8'd0,   16'h8001};
    lt[6] = '{1'b0, 8'd3,   16'hF0FF};
    lt[7] = '{1'b1, 8'd255, 16'h5555};

    rt[0] = '{8'd0, 4'h3, 8'h05, 16'h00AA};
    rt[1] = '{8'd1, 4'hA, 8'h07, 16'hBEEF};
    rt[2] = '{8'd2, 4'hF, 8'h00, 16'h8001};
    rt[3] = '{8'd3, 4'h0, 8'hFF, 16'h5555};

    pc = '0; we = 1'b0; wdata = '0;
    ld.ld_valid = 1'b0; ld.ld_sel = 1'b0; ld.ld_addr = '0;
    ld.ld_data = '0; ld.ld_done = 1'b0; ld.ld_start = 1'b0;

    // Reset state
    #2;
    want(S_CPURST, 32'h0, "reset_cpu_rst_n");
    want(S_RUNNING, 32'h0, "reset_running");
    want(S_RUNCNT, 32'h0, "reset_run_cnt");
    want(S_READY, 32'h1, "reset_ld_ready");
    drain();
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Load image; last word arrives together with ld_done; a CPU store
    // attempted mid-load must be ignored.
    for (int i = 0; i < 8; i++) begin
      ld.ld_valid = 1'b1;
      ld.ld_sel   = lt[i].sel;
      ld.ld_addr  = lt[i].addr;
      ld.ld_data  = lt[i].data;
      ld.ld_done  = (i == 7);
      we          = (i == 3);
      wdata       = 16'hDEAD;
      want(S_READY, 32'h1, "ld_ready_in_load");
      want(S_CPURST, 32'h0, "cpu_rst_n_in_load");
      @(negedge clk);
      drain();
      tick();
    end

    // RELEASE: store and ld_start both ignored
    ld.ld_valid = 1'b0; ld.ld_done = 1'b0;
    we = 1'b1; wdata = 16'hDEAD; ld.ld_start = 1'b1;
    want(S_CPURST, 32'h0, "release_cpu_rst_n");
    want(S_READY, 32'h0, "release_ld_ready");
    want(S_RUNNING, 32'h0, "release_running");
    want(S_RUNCNT, 32'h0, "release_run_cnt");
    @(negedge clk);
    drain();
    tick();
    model_run = 1'b1;
    we = 1'b0; ld.ld_start = 1'b0;

    // First RUN cycle (two edges after ld_done); stray ld_done is ignored
    ld.ld_done = 1'b1;
    want(S_CPURST, 32'h1, "run_cpu_rst_n");
    want(S_RUNNING, 32'h1, "run_running");
    want(S_READY, 32'h0, "run_ld_ready");
    want(S_RUNCNT, 32'(exp_cnt), "run_cnt_first");
    @(negedge clk);
    drain();
    tick();
    ld.ld_done = 1'b0;

    // Fetch table
    for (int i = 0; i < 4; i++) begin
      pc = rt[i].pc;
      want(S_OPCODE, 32'(rt[i].op), "fetch_opcode");
      want(S_OPERAND, 32'(rt[i].opnd), "fetch_operand");
      want(S_DDATA, 32'(rt[i].dd), "fetch_ddatain");
      want(S_RUNNING, 32'h1, "still_running");
      @(negedge clk);
      drain();
      tick();
    end
    want(S_RUNCNT, 32'(exp_cnt), "run_cnt_counting");
    @(negedge clk);
    drain();

    // CPU store: old value this cycle, new value next cycle
    tick();
    pc = 8'd0; we = 1'b1; wdata = 16'h1234;
    want(S_DDATA, 32'h00AA, "store_same_cycle_old");
    @(negedge clk);
    drain();
    tick();
    we = 1'b0;
    want(S_DDATA, 32'h1234, "store_next_cycle_new");
    @(negedge clk);
    drain();
    tick();

    // Loader word during RUN is refused
    ld.ld_valid = 1'b1; ld.ld_sel = 1'b1; ld.ld_addr = 8'd5; ld.ld_data = 16'hFFFF;
    want(S_READY, 32'h0, "run_loader_refused");
    @(negedge clk);
    drain();
    tick();
    ld.ld_valid = 1'b0;
    want(S_DDATA, 32'h1234, "run_loader_no_write");
    @(negedge clk);
    drain();
    tick();

    // ld_start with a simultaneous store
    ld.ld_start = 1'b1; we = 1'b1; wdata = 16'h5678;
    want(S_RUNNING, 32'h1, "ld_start_cycle_running");
    want(S_CPURST, 32'h1, "ld_start_cycle_cpu_rst_n");
    @(negedge clk);
    drain();
    tick();
    model_run = 1'b0;
    ld.ld_start = 1'b0; we = 1'b1; wdata = 16'h9999;
    want(S_CPURST, 32'h0, "after_ld_start_cpu_rst_n");
    want(S_READY, 32'h1, "after_ld_start_ld_ready");
    want(S_RUNNING, 32'h0, "after_ld_start_running");
    want(S_DDATA, 32'h5678, "ld_start_store_landed");
    want(S_RUNCNT, 32'(exp_cnt), "run_cnt_after_ld_start");
    @(negedge clk);
    drain();
    tick();
    we = 1'b0;
    want(S_RUNCNT, 32'(exp_cnt), "run_cnt_frozen_load");
    want(S_DDATA, 32'h5678, "store_ignored_in_load");
    @(negedge clk);
    drain();

    // Back to RUN and run long enough to saturate the counter
    ld.ld_done = 1'b1;
    tick();
    ld.ld_done = 1'b0;
    exp_cnt = 0;
    want(S_RUNCNT, 32'h0, "run_cnt_clear_release");
    @(negedge clk);
    drain();
    tick();
    model_run = 1'b1;
    repeat (70000) tick();
    want(S_RUNCNT, 32'(exp_cnt), "run_cnt_model_sat");
    want(S_RUNCNT, 32'hFFFF, "run_cnt_saturated");
    @(negedge clk);
    drain();
    repeat (5) tick();
    want(S_RUNCNT, 32'hFFFF, "run_cnt_holds_sat");
    @(negedge clk);
    drain();

    // Asynchronous reset mid-RUN
    tick();
    pc = 8'd0;
    #2;
    rst_n = 1'b0;
    #1;
    model_run = 1'b0;
    exp_cnt = 0;
    want(S_CPURST, 32'h0, "async_rst_cpu_rst_n");
    want(S_RUNCNT, 32'h0, "async_rst_run_cnt");
    want(S_RUNNING, 32'h0, "async_rst_running");
    want(S_DDATA, 32'h5678, "async_rst_dmem_kept");
    drain();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    want(S_READY, 32'h1, "post_rst_ld_ready");
    want(S_RUNNING, 32'h0, "post_rst_state_load");
    want(S_OPCODE, 32'h3, "post_rst_imem_kept");
    @(negedge clk);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
